// File: rtl/pulse_sync_arbiter.sv
// Round-robin arbiter that shares one pulse synchronizer between N_REQ fast-domain event sources.
// Build option: define PULSE_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module pulse_sync_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned RISE_TMO = 4
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             sync_busy_i,
  output logic             sync_sig_o,
  output logic [ID_W-1:0]  evt_id_o,
  output logic [N_REQ-1:0] pending_o,
  output logic [N_REQ-1:0] drop_o,
  output logic [7:0]       drop_cnt_o,
  output logic             tmo_err_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned POP_W = $clog2(N_REQ + 1);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TMO_W = $clog2(RISE_TMO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_GUARD
  } state_e;

  state_e             state_q, state_d;
  logic               sync_sig_q, sync_sig_d;
  logic               tmo_err_q, tmo_err_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`ifndef PULSE_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

  logic               found_c;
  logic [PTR_W-1:0]   winner_c;
  logic [N_REQ-1:0]   clr_c;
  logic [POP_W-1:0]   drop_pop_c;
  logic [SUM_W-1:0]   drop_sum_c;

  // Winner search over the pending vector
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
`ifdef PULSE_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found_c  = 1'b1;
        winner_c = PTR_W'(i);
      end
    end
`else
    // Descending scan so the entry closest after the pointer is the last one kept
    for (int k = N_REQ; k >= 1; k--) begin
      if (pending_q[PTR_W'((int'(ptr_q) + k) % N_REQ)]) begin
        found_c  = 1'b1;
        winner_c = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
`endif
  end

  // Transfer sequencing FSM: next state and registered-output next values
  always_comb begin
    state_d    = state_q;
    sync_sig_d = 1'b0;
    tmo_err_d  = 1'b0;
    evt_id_d   = evt_id_q;
    tmo_cnt_d  = tmo_cnt_q;
    clr_c      = '0;
`ifndef PULSE_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          state_d         = ST_LAUNCH;
          sync_sig_d      = 1'b1;
          evt_id_d        = ID_W'(winner_c);
          clr_c[winner_c] = 1'b1;
`ifndef PULSE_ARB_FIXED_PRIO_EN
          ptr_d           = winner_c;
`endif
        end
      end
      ST_LAUNCH: begin
        state_d   = ST_WAIT_RISE;
        tmo_cnt_d = TMO_W'(1);
      end
      ST_WAIT_RISE: begin
        if (sync_busy_i) begin
          state_d = ST_WAIT_FALL;
        end else if (tmo_cnt_q == TMO_W'(RISE_TMO)) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (!sync_busy_i) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture: a grant-clear and a same-cycle request resolve to set
  always_comb begin
    pending_d  = (pending_q & ~clr_c) | req_i;
    drop_d     = req_i & pending_q & ~clr_c;
    drop_pop_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drop_pop_c = drop_pop_c + POP_W'(drop_d[i]);
    end
    drop_sum_c = SUM_W'(drop_cnt_q) + SUM_W'(drop_pop_c);
    drop_cnt_d = (drop_sum_c > SUM_W'(255)) ? CNT_W'(255) : drop_sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk_a or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sync_sig_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      evt_id_q   <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      drop_cnt_q <= '0;
      tmo_cnt_q  <= '0;
`ifndef PULSE_ARB_FIXED_PRIO_EN
      ptr_q      <= PTR_W'(N_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      sync_sig_q <= sync_sig_d;
      tmo_err_q  <= tmo_err_d;
      evt_id_q   <= evt_id_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
`ifndef PULSE_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign sync_sig_o = sync_sig_q;
  assign evt_id_o   = evt_id_q;
  assign pending_o  = pending_q;
  assign drop_o     = drop_q;
  assign drop_cnt_o = drop_cnt_q;
  assign tmo_err_o  = tmo_err_q;

endmodule
